// File: rtl/spi_adc_scanner_pkg.sv
// Shared types and command-byte layout for the SPI ADC scanner.
package spi_adc_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FRAME = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          CMD_BITS    = 8;
  localparam int          CMD_START   = 7;
  localparam int          CMD_ADDR_LO = 4;
  localparam int          CMD_LSB_LO  = 0;
  localparam logic [23:0] DEF_CH_ADDR = 24'hFAC5;
  localparam logic [3:0]  DEF_CMD_LSB = 4'b0011;

  function automatic logic [CMD_BITS-1:0] cmd_byte(input logic [2:0] addr, input logic [3:0] lsb);
    logic [CMD_BITS-1:0] c;
    c                       = '0;
    c[CMD_START]            = 1'b1;
    c[CMD_ADDR_LO +: 3]     = addr;
    c[CMD_LSB_LO +: 4]      = lsb;
    return c;
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// One SPI frame: TX_N command bits, one busy slot, RX_N data bits, TRAIL idle clocks.
// MOSI changes on falling sclk, MISO/busy sampled on rising sclk.
module spi_frame_engine #(
  parameter int CLK_DIV = 25,
  parameter int TX_N    = 8,
  parameter int RX_N    = 12,
  parameter int TRAIL   = 3
) (
  input  logic            cclk,
  input  logic            rstb,
  input  logic            go,
  input  logic [TX_N-1:0] tx_data,
  input  logic            miso,
  input  logic            busy_in,
  output logic            sclk,
  output logic            mosi,
  output logic [RX_N-1:0] rx_data,
  output logic            bad,
  output logic            done
);
  localparam int NBIT = TX_N + 1 + RX_N + TRAIL;
  localparam int BW   = $clog2(NBIT);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic            active;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [TX_N-1:0] tx_sr;
  logic            tick, rise, fall;

  assign tick = active && (div_cnt == DW'(CLK_DIV-1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_data <= '0;
      bad     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        // First command bit is presented a half period before the first rising edge.
        active  <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
        mosi    <= tx_data[TX_N-1];
        tx_sr   <= {tx_data[TX_N-2:0], 1'b0};
        bad     <= 1'b0;
      end else if (active) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (rise) begin
          sclk <= 1'b1;
          if (bit_cnt == BW'(TX_N))
            bad <= busy_in;
          else if (bit_cnt > BW'(TX_N) && bit_cnt <= BW'(TX_N + RX_N))
            rx_data <= {rx_data[RX_N-2:0], miso};
        end
        if (fall) begin
          sclk  <= 1'b0;
          mosi  <= tx_sr[TX_N-1];
          tx_sr <= {tx_sr[TX_N-2:0], 1'b0};
          if (bit_cnt == BW'(NBIT-1)) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_adc_scanner.sv
// Round-robin multi-channel SPI ADC scanner: keeps the last of REPEAT good
// conversions per channel visit and publishes it per channel.
module spi_adc_scanner
  import spi_adc_scanner_pkg::*;
#(
  parameter int          N_CH    = 3,
  parameter int          RES     = 12,
  parameter int          CLK_DIV = 25,
  parameter int          REPEAT  = 8,
  parameter int          TRAIL   = 3,
  parameter logic [23:0] CH_ADDR = DEF_CH_ADDR,
  parameter logic [3:0]  CMD_LSB = DEF_CMD_LSB
) (
  input  logic                cclk,
  input  logic                rstb,
  input  logic                enable,
  input  logic                single_shot,
  input  logic                start,
  input  logic                adc_busy,
  input  logic                adc_dout,
  output logic                sclk,
  output logic                adc_din,
  output logic                csb,
  output logic [RES-1:0]      sample,
  output logic [2:0]          sample_ch,
  output logic                sample_stb,
  output logic [N_CH*RES-1:0] results,
  output logic                scan_done,
  output logic                busy
);
  localparam int CW = (N_CH > 1)    ? $clog2(N_CH)    : 1;
  localparam int RW = (REPEAT > 1)  ? $clog2(REPEAT)  : 1;
  localparam int SW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t                   state, state_nx;
  logic [CW-1:0]            ch;
  logic [RW-1:0]            rep;
  logic [SW-1:0]            setup_cnt;
  logic [N_CH-1:0][RES-1:0] res_q;
  logic [CMD_BITS-1:0]      cmd;
  logic [RES-1:0]           fe_rx;
  logic                     go, fe_done, fe_bad;
  logic                     store, wrap, last_setup;

  // Strobes are raised during DONE; the registers they announce load at its end.
  assign store      = (state == ST_DONE) && !fe_bad && (rep == RW'(REPEAT-1));
  assign wrap       = store && (ch == CW'(N_CH-1));
  assign last_setup = (setup_cnt == SW'(CLK_DIV-1));
  assign sample_stb = store;
  assign scan_done  = wrap;
  assign busy       = (state != ST_IDLE);
  assign csb        = (state == ST_IDLE);
  assign results    = res_q;
  assign cmd        = cmd_byte(CH_ADDR[3*ch +: 3], CMD_LSB);

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    case (state)
      ST_IDLE:  if (enable && (!single_shot || start)) state_nx = ST_SETUP;
      ST_SETUP: if (last_setup) begin
                  go       = 1'b1;
                  state_nx = ST_FRAME;
                end
      ST_FRAME: if (fe_done) state_nx = ST_DONE;
      ST_DONE:  state_nx = (enable && !(single_shot && wrap)) ? ST_SETUP : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_IDLE;
      setup_cnt <= '0;
    end else begin
      state     <= state_nx;
      setup_cnt <= (state == ST_SETUP && !last_setup) ? setup_cnt + 1'b1 : '0;
    end
  end

  // A frame flagged busy by the ADC neither stores nor counts: the repeat is retried.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      ch        <= '0;
      rep       <= '0;
      res_q     <= '0;
      sample    <= '0;
      sample_ch <= '0;
    end else if (state == ST_DONE && !fe_bad) begin
      if (store) begin
        res_q[ch] <= fe_rx;
        sample    <= fe_rx;
        sample_ch <= 3'(ch);
        rep       <= '0;
        ch        <= wrap ? '0 : ch + 1'b1;
      end else begin
        rep <= rep + 1'b1;
      end
    end
  end

  spi_frame_engine #(
    .CLK_DIV (CLK_DIV),
    .TX_N    (CMD_BITS),
    .RX_N    (RES),
    .TRAIL   (TRAIL)
  ) u_frame (
    .cclk    (cclk),
    .rstb    (rstb),
    .go      (go),
    .tx_data (cmd),
    .miso    (adc_dout),
    .busy_in (adc_busy),
    .sclk    (sclk),
    .mosi    (adc_din),
    .rx_data (fe_rx),
    .bad     (fe_bad),
    .done    (fe_done)
  );

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench for spi_adc_scanner with a behavioural ADC that decodes the command byte.
module tb_spi_adc_scanner;
  localparam int N_CH = 3, RES = 12, CLK_DIV = 25, REPEAT = 4, TRAIL = 3;
  localparam int NBIT = 8 + 1 + RES + TRAIL;

  logic                cclk = 1'b0, rstb = 1'b0, enable = 1'b0, single_shot = 1'b0, start = 1'b0;
  logic                adc_busy, adc_dout = 1'b0;
  logic                sclk, adc_din, csb, sample_stb, scan_done, busy;
  logic [RES-1:0]      sample;
  logic [2:0]          sample_ch;
  logic [N_CH*RES-1:0] results;

  spi_adc_scanner #(.N_CH(N_CH), .RES(RES), .CLK_DIV(CLK_DIV), .REPEAT(REPEAT), .TRAIL(TRAIL)) dut (
    .cclk(cclk), .rstb(rstb), .enable(enable), .single_shot(single_shot), .start(start),
    .adc_busy(adc_busy), .adc_dout(adc_dout), .sclk(sclk), .adc_din(adc_din), .csb(csb),
    .sample(sample), .sample_ch(sample_ch), .sample_stb(sample_stb), .results(results),
    .scan_done(scan_done), .busy(busy)
  );

  always #5 cclk = ~cclk;

  int n_err = 0, n_checks = 0;

  // ---------------- ADC model ----------------
  int         k = 0, frames = 0, data_mode = 0, busy_at = -1, bitsel;
  logic [7:0] cmd = '0;
  logic [7:0] cmd_log [64];
  logic [RES-1:0] word;

  function automatic logic [RES-1:0] adc_word(input logic [2:0] a, input int f, input int mode);
    if (mode == 1) return RES'(f + 1);
    case (a)
      3'd5:    return 12'hA5C;
      3'd0:    return 12'h3F1;
      3'd3:    return 12'h07E;
      default: return 12'hFFF;
    endcase
  endfunction

  assign adc_busy = (frames == busy_at);

  always @(posedge sclk or negedge rstb) begin
    if (!rstb) begin
      k = 0; frames = 0; cmd = '0; adc_dout = 1'b0;
    end else begin
      if (k < 8) cmd = {cmd[6:0], adc_din};
      if (k == 7 && frames < 64) cmd_log[frames] = cmd;
      k++;
      if (k == NBIT) begin k = 0; frames++; end
      word = adc_word(cmd[6:4], frames, data_mode);
      if (k >= 9 && k < 9 + RES) begin
        bitsel   = RES - 1 - (k - 9);
        adc_dout = word[bitsel[3:0]];
      end else begin
        adc_dout = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0, stb_cnt = 0, done_cnt = 0, last_rise = -1, per_ok = 0, per_bad = 0, din_bad = 0;
  logic prev_sclk = 1'b0, prev_din = 1'b0;

  always @(negedge cclk) begin
    cyc++;
    if (sample_stb) stb_cnt++;
    if (scan_done) done_cnt++;
    if (!rstb) last_rise = -1;
    else if (sclk && !prev_sclk) begin
      if (last_rise >= 0) begin
        if (cyc - last_rise == 50) per_ok++;
        else if (cyc - last_rise < 60) per_bad++;
      end
      last_rise = cyc;
    end
    if (rstb && sclk && adc_din !== prev_din) din_bad++;
    prev_sclk = sclk;
    prev_din  = adc_din;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic do_reset();
    rstb = 1'b0; enable = 1'b0; single_shot = 1'b0; start = 1'b0; busy_at = -1;
    repeat (3) @(negedge cclk);
    rstb = 1'b1;
    @(negedge cclk);
  endtask

  task automatic wait_stb(input string name, output int fr);
    int n = 0;
    fr = -1;
    while (!sample_stb && n < 8000) begin @(negedge cclk); n++; end
    if (!sample_stb) timeout(name);
    else fr = frames;
    @(negedge cclk);
  endtask

  task automatic wait_frames(input string name, input int target);
    int n = 0;
    while (frames < target && n < 20000) begin @(negedge cclk); n++; end
    if (frames < target) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20000) begin @(negedge cclk); n++; end
    if (busy) timeout(name);
  endtask

  task automatic pulse_start();
    @(negedge cclk); start = 1'b1;
    @(negedge cclk); start = 1'b0;
  endtask

  typedef struct {
    int              frames;  // frames completed when the strobe fires
    logic [2:0]      ch;
    logic [RES-1:0]  smp;
    logic [35:0]     res;
    int              dones;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int fr, s0, d0, n, cnt;
    logic ps;

    tbl[0] = '{4,  3'd0, 12'hA5C, {12'h000, 12'h000, 12'hA5C}, 0};
    tbl[1] = '{8,  3'd1, 12'h3F1, {12'h000, 12'h3F1, 12'hA5C}, 0};
    tbl[2] = '{12, 3'd2, 12'h07E, {12'h07E, 12'h3F1, 12'hA5C}, 1};
    tbl[3] = '{16, 3'd0, 12'hA5C, {12'h07E, 12'h3F1, 12'hA5C}, 1};

    // Reset state
    repeat (2) @(negedge cclk);
    check("rst csb", csb, 1'b1);
    check("rst sclk", sclk, 1'b0);
    check("rst adc_din", adc_din, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst results", results, '0);
    check("rst sample", sample, '0);
    check("rst strobes", {sample_stb, scan_done}, 2'b00);
    do_reset();

    // Continuous scan with fixed per-address ADC replies
    data_mode = 0;
    d0 = done_cnt;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_stb($sformatf("scan stb %0d", i), fr);
      check($sformatf("scan[%0d] frame", i), fr, tbl[i].frames);
      check($sformatf("scan[%0d] sample_ch", i), sample_ch, tbl[i].ch);
      check($sformatf("scan[%0d] sample", i), sample, tbl[i].smp);
      check($sformatf("scan[%0d] results", i), results, tbl[i].res);
      check($sformatf("scan[%0d] scan_done", i), done_cnt - d0, tbl[i].dones);
    end
    check("cmd ch0", cmd_log[0], 8'hD3);
    check("cmd ch1", cmd_log[4], 8'h83);
    check("cmd ch2", cmd_log[8], 8'hB3);

    // Reset mid-frame at the 10th rising sclk edge
    n = 0; cnt = 0; ps = sclk;
    while (n < 10 && cnt < 5000) begin
      @(negedge cclk); cnt++;
      if (sclk && !ps) n++;
      ps = sclk;
    end
    check("mid csb before reset", csb, 1'b0);
    rstb = 1'b0;
    #1;
    check("mid rst csb", csb, 1'b1);
    check("mid rst sclk", sclk, 1'b0);
    check("mid rst results", results, '0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst adc_din", adc_din, 1'b0);
    do_reset();

    // Per-frame data 1,2,3,4 on ch0: only the last is stored
    data_mode = 1;
    s0 = stb_cnt;
    enable = 1'b1;
    wait_stb("rep stb", fr);
    check("rep frame", fr, 4);
    check("rep sample", sample, 12'd4);
    check("rep sample_ch", sample_ch, 3'd0);
    check("rep results ch0", results[11:0], 12'd4);
    check("rep one strobe", stb_cnt - s0, 1);
    do_reset();
    data_mode = 0;

    // ADC busy in the third frame of ch1 (global frame 6) forces a retry
    busy_at = 6;
    enable = 1'b1;
    wait_stb("busy stb ch0", fr);
    check("busy ch0 frame", fr, 4);
    wait_stb("busy stb ch1", fr);
    check("busy ch1 frame", fr, 9);
    check("busy ch1 sample_ch", sample_ch, 3'd1);
    check("busy ch1 sample", sample, 12'h3F1);
    check("busy retry cmd", cmd_log[7], 8'h83);
    do_reset();

    // Enable dropped mid-frame of ch1, then resumed
    s0 = stb_cnt;
    enable = 1'b1;
    wait_frames("en frames", 5);
    repeat (600) @(negedge cclk);
    enable = 1'b0;
    wait_idle("en idle");
    check("en frame completed", frames, 6);
    check("en csb idle", csb, 1'b1);
    check("en strobes", stb_cnt - s0, 1);
    repeat (500) @(negedge cclk);
    check("en stays idle", frames, 6);
    enable = 1'b1;
    wait_stb("en resume stb", fr);
    check("en resume frame", fr, 8);
    check("en resume sample_ch", sample_ch, 3'd1);
    check("en resume cmd", cmd_log[6], 8'h83);
    check("sclk period 50 seen", per_ok > 0, 1'b1);
    check("sclk bad periods", per_bad, 0);
    check("adc_din change while sclk high", din_bad, 0);
    do_reset();

    // Single-shot pass
    s0 = stb_cnt; d0 = done_cnt;
    single_shot = 1'b1;
    enable = 1'b1;
    repeat (100) @(negedge cclk);
    check("ss waits for start", {busy, csb}, 2'b01);
    pulse_start();
    wait_frames("ss frames", 3);
    pulse_start();
    wait_idle("ss idle");
    check("ss frame count", frames, N_CH * REPEAT);
    check("ss strobes", stb_cnt - s0, N_CH);
    check("ss scan_done", done_cnt - d0, 1);
    check("ss csb", csb, 1'b1);
    check("ss busy", busy, 1'b0);
    repeat (3000) @(negedge cclk);
    check("ss no restart", frames, N_CH * REPEAT);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
